register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the register and data-port width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning the register count, addressed by the 5-bit register-select fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port write_en, input, 1, write-port enable.
REQ-006 SHALL have port write_addr, input, 5, destination register index produced by the destination-select mux.
REQ-007 SHALL have port write_data, input, DATA_WIDTH, value to store.
REQ-008 SHALL have ports read_addr1 and read_addr2, input, 5 each, source register indices.
REQ-009 SHALL have ports read_data1 and read_data2, output, DATA_WIDTH each, source register values.

Function
REQ-010 SHALL hold NUM_REGS registers of DATA_WIDTH bits each.
REQ-011 SHALL decode write_addr into one-hot per-register write enables, gated by write_en.
REQ-012 SHALL load write_data into register[write_addr] on a clk rising edge when write_en=1 and reset=0.
REQ-013 SHALL hard-wire register 0 to zero: writes to address 0 are discarded, and reads of address 0 return 0.
REQ-014 SHALL leave every register unchanged on a clk edge when write_en=0.
REQ-015 SHALL drive read_data1 and read_data2 combinationally from read_addr1 and read_addr2, with zero-cycle latency.
REQ-016 SHALL permit both read ports to address the same register simultaneously, returning identical values.
REQ-017 SHALL return the pre-edge stored value when a read address equals write_addr in the same cycle, unless the REQ-024 behaviour applies.
REQ-018 SHALL update the stored value so that it is visible on the read ports immediately after the writing clk edge.

Reset
REQ-019 SHALL clear all registers to 0 immediately on reset assertion, without waiting for clk.
REQ-020 SHALL drive read_data1 and read_data2 to 0 for every address while reset=1.
REQ-021 SHALL ignore write_en for as long as reset=1; a write coincident with the reset-asserting edge is discarded.
REQ-022 SHALL accept writes beginning with the first clk rising edge after reset deasserts.

Configuration
REQ-023 SHALL compile a write-to-read bypass under macro REGISTER_FILE_WRITE_FORWARD_EN.
REQ-024 SHALL, with REGISTER_FILE_WRITE_FORWARD_EN defined, drive write_data on a read port when write_en=1, write_addr is nonzero, and that port's read address equals write_addr, in the same cycle.
REQ-025 SHALL, without the macro, behave exactly as REQ-017, returning the old stored value.
REQ-026 SHALL never forward to address 0, whether or not the macro is defined.

Verification
REQ-027 SHALL cover reset clearing: write 0xDEADBEEF to r5, then pulse reset with clk stopped -> read_data1 for r5 = 0 at once.
REQ-028 SHALL cover basic write/read: write 0x12345678 to r31 and 0xA5A5A5A5 to r1, then set read_addr1=31 and read_addr2=1 -> read_data1=0x12345678 and read_data2=0xA5A5A5A5.
REQ-029 SHALL cover the zero register: write 0xFFFFFFFF to r0 with write_en=1 -> both ports read 0 from r0, and r1..r31 are unchanged.
REQ-030 SHALL cover the enable gate: write_en=0, write_addr=7, write_data=0x55 -> r7 keeps its prior value, 0.
REQ-031 SHALL cover same-cycle read/write: r9=0x11, then write 0x22 to r9 with read_addr1=9 before the edge -> read_data1=0x11 without the macro, 0x22 with the macro, and 0x22 after the edge in both builds.
REQ-032 SHALL cover write during reset: reset=1 with write_en=1, write_addr=3, write_data=0x77, then deassert reset -> r3=0.

Source files
------------

// File: rtl/register_file.sv
// register_file: multi-ported general-purpose register file.
//
// Purpose
//   NUM_REGS registers of DATA_WIDTH bits with one synchronous write port and
//   two combinational read ports. Register 0 is hard-wired to zero.
//
// Configuration
//   REGISTER_FILE_WRITE_FORWARD_EN : when defined, a read port whose address
//   matches an active, nonzero write address returns write_data in the same
//   cycle. When undefined, the read port returns the pre-edge stored value.
//
// Ports
//   clk        : rising-edge clock for all state updates
//   reset      : asynchronous active-high reset, clears every register
//   write_en   : write-port enable
//   write_addr : destination register index
//   write_data : value to store
//   read_addr1 : source register index for port 1
//   read_addr2 : source register index for port 2
//   read_data1 : value of register[read_addr1]
//   read_data2 : value of register[read_addr2]

module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [4:0]            write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_addr1,
  input  logic [4:0]            read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  // Register 0 has no storage; it always reads as zero.
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

  logic [NUM_REGS-1:1]   w_we_onehot;
  logic                  w_we_any;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // One-hot write decode. Address 0 and out-of-range addresses decode to no
  // enable, so those writes are silently dropped.
  always_comb begin
    w_we_onehot = '0;
    if (write_en) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        w_we_onehot[i] = (int'(write_addr) == i);
      end
    end
  end

  assign w_we_any = |w_we_onehot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (w_we_onehot[i]) begin
          r_regs[i] <= write_data;
        end
      end
    end
  end

  // Read muxes. Reset forces zero so a forwarded write_data cannot leak out
  // while the array is held clear.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (!reset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (int'(read_addr1) == i) begin
          w_rd1 = r_regs[i];
        end
        if (int'(read_addr2) == i) begin
          w_rd2 = r_regs[i];
        end
      end
`ifdef REGISTER_FILE_WRITE_FORWARD_EN
      // w_we_any already excludes address 0, so r0 is never forwarded.
      if (w_we_any && (read_addr1 == write_addr)) begin
        w_rd1 = write_data;
      end
      if (w_we_any && (read_addr2 == write_addr)) begin
        w_rd2 = write_data;
      end
`endif
    end
  end

`ifndef REGISTER_FILE_WRITE_FORWARD_EN
  // Only consumed by the forwarding path.
  logic w_unused_we_any;
  assign w_unused_we_any = w_we_any;
`endif

  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

`ifdef REGISTER_FILE_WRITE_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        reset;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  register_file #(
    .DATA_WIDTH(32),
    .NUM_REGS  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  // Gated clock so the reset-with-clock-stopped case can be exercised.
  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // Reference model: an array of stored values, updated by plain rules.
  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  event probe;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_issued = 0;

  function automatic logic [31:0] exp_read(logic [4:0] ra);
    if (reset) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (Fwd && write_en && (write_addr == ra)) return write_data;
    return model[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Push the expected response for the current inputs and tell the monitor.
  task automatic expect_now(string name);
    exp_t e;
    e.name = name;
    e.e1   = exp_read(read_addr1);
    e.e2   = exp_read(read_addr2);
    q.push_back(e);
    n_issued += 2;
    -> probe;
    #1;
  endtask

  // Monitor: pops expectations and compares against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(probe);
      while (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (read_data1 === e.e1) n_pass++;
        else $display("FAIL %s port1: got %h expected %h", e.name, read_data1, e.e1);
        n_checks++;
        if (read_data2 === e.e2) n_pass++;
        else $display("FAIL %s port2: got %h expected %h", e.name, read_data2, e.e2);
      end
    end
  end

  // One full clock cycle: drive at clock-low, check before and after the edge.
  task automatic cycle(string name, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra1, logic [4:0] ra2);
    write_en   = we;
    write_addr = wa;
    write_data = wd;
    read_addr1 = ra1;
    read_addr2 = ra2;
    #1;
    expect_now({name, "_pre"});
    @(posedge clk);
    if (!reset && we && wa != 5'd0) model[wa] = wd;
    #1;
    expect_now({name, "_post"});
    @(negedge clk);
  endtask

  initial begin
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] wd;

    reset      = 1'b1;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = 5'd5;
    read_addr2 = 5'd31;
    model_clear();
    repeat (2) @(negedge clk);
    expect_now("reset_state");
    reset = 1'b0;
    #1;
    expect_now("after_reset_release");
    @(negedge clk);

    // Reset clears immediately with the clock stopped.
    cycle("w_r5", 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    clk_run  = 1'b0;
    write_en = 1'b0;
    #1;
    expect_now("r5_before_reset");
    reset = 1'b1;
    model_clear();
    #1;
    expect_now("r5_async_clear");
    reset = 1'b0;
    #1;
    expect_now("r5_after_clear");
    clk_run = 1'b1;
    @(negedge clk);

    // Basic write/read on both ports.
    cycle("w_r31", 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd1);
    cycle("w_r1",  1'b1, 5'd1,  32'hA5A5A5A5, 5'd31, 5'd1);
    cycle("rd_31_1", 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);

    // Zero register: write discarded, other registers untouched.
    cycle("w_r0", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    for (int i = 0; i < 32; i += 2) begin
      cycle($sformatf("scan_%0d", i), 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));
    end

    // Enable gate.
    cycle("we0_r7", 1'b0, 5'd7, 32'h55, 5'd7, 5'd7);

    // Same-cycle read/write (forwarding depends on build).
    cycle("w_r9_11", 1'b1, 5'd9, 32'h11, 5'd9, 5'd0);
    cycle("w_r9_22", 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
    cycle("rd_r9",   1'b0, 5'd0, 32'h0,  5'd9, 5'd9);

    // Write during reset is discarded.
    reset      = 1'b1;
    write_en   = 1'b1;
    write_addr = 5'd3;
    write_data = 32'h77;
    read_addr1 = 5'd3;
    read_addr2 = 5'd9;
    model_clear();
    #1;
    expect_now("rst_write_pre");
    @(posedge clk);
    #1;
    expect_now("rst_write_edge");
    @(negedge clk);
    write_en = 1'b0;
    reset    = 1'b0;
    #1;
    expect_now("rst_write_r3");
    @(negedge clk);
    cycle("first_write_after_reset", 1'b1, 5'd3, 32'h3333, 5'd3, 5'd3);

    // Randomized traffic with biased address collisions.
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
      cycle($sformatf("rand_%0d", n), we, wa, wd, ra1, ra2);
    end

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 20 && q.size() > 0; t++) #1;
    if (q.size() != 0 || n_checks != n_issued) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, %0d compared expected 0 pending, %0d compared",
               q.size(), n_checks - 1, n_issued);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
